async_fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares the write port of the async FIFO (wdata/winc/wfull) among NREQ producers in the write-clock domain.
- Each producer uses a valid/ready handshake.
- The arbiter grants one producer at a time for a bounded burst, forwards that producer's data to the FIFO, and stalls on wfull.
- It sits between the producer blocks and the FIFO write side, and is clocked by wclk only.

---
 rtl/async_fifo_wr_arbiter.sv | 156 +++++++++++++++
 tb/tb_async_fifo_wr_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// async_fifo_wr_arbiter
//
// Shares the write port of an asynchronous FIFO among NREQ producers that sit
// in the write-clock domain. Each producer uses a valid/ready handshake. The
// arbiter grants one producer at a time, round-robin, for a burst of at most
// MAX_BURST beats. It forwards that producer's data straight to the FIFO and
// holds the grant while the FIFO reports full.
//
// Ports
//   wclk       write-domain clock; all state changes on its rising edge
//   wrst_n     asynchronous active-low reset
//   req_valid  per-requester data valid                        [NREQ]
//   req_data   packed requester data, requester i at [i*DSIZE +: DSIZE]
//   req_ready  per-requester accept, one-hot or zero           [NREQ]
//   wfull      FIFO full flag
//   winc       FIFO write enable
//   wdata      FIFO write data                                 [DSIZE]
//   grant_id   index of the current (or most recent) grant     [IW]
//   busy       high while a requester holds the grant
//
// Timing
//   Arbitration takes one IDLE cycle. During GRANT, winc/req_ready/wdata are
//   combinational from the registered grant plus req_valid/wfull, so a beat
//   happens in the same cycle the producer presents valid data.
// ---------------------------------------------------------------------------
module async_fifo_wr_arbiter #(
    parameter  int DSIZE     = 8,
    parameter  int NREQ      = 4,
    parameter  int MAX_BURST = 4,
    localparam int IW        = $clog2(NREQ)
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic [IW-1:0]         grant_id,
    output logic                  busy
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Beat counter limit; burst_cnt never runs past this value.
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    state_t          state_reg;
    // grant_reg is both the active grant and the round-robin pointer: it is
    // only rewritten when a new grant is made, so in IDLE it still names the
    // requester served last.
    logic [IW-1:0]   grant_reg;
    logic [7:0]      burst_cnt_reg;

    logic [DSIZE-1:0] data_arr [NREQ];
    logic             granted;
    logic             beat;
    logic             last_beat;
    logic             pick_found;
    logic [IW-1:0]    pick_idx;

    // -----------------------------------------------------------------------
    // Unpack requester data into an indexable array
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign data_arr[gi] = req_data[gi*DSIZE +: DSIZE];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Round-robin pick: scan last+1, last+2, ... wrapping modulo NREQ.
    // The running sum is one bit wider than the index so the wrap works for
    // requester counts that are not a power of two.
    // -----------------------------------------------------------------------
    always_comb begin
        logic [IW:0] cand;
        pick_found = 1'b0;
        pick_idx   = grant_reg;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, grant_reg} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (!pick_found && req_valid[cand[IW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IW-1:0];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Beat qualification. wfull blocks the beat outright, so winc can never
    // be raised into a full FIFO.
    // -----------------------------------------------------------------------
    assign granted   = (state_reg == ST_GRANT);
    assign beat      = granted && req_valid[grant_reg] && !wfull;
    assign last_beat = (burst_cnt_reg == BURST_LAST);

    // -----------------------------------------------------------------------
    // Arbitration FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_reg     <= ST_IDLE;
            grant_reg     <= IW'(NREQ - 1);
            burst_cnt_reg <= 8'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_reg     <= pick_idx;
                        burst_cnt_reg <= 8'd0;
                        state_reg     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!req_valid[grant_reg]) begin
                        // Producer withdrew: release the grant even if the
                        // FIFO is currently full.
                        state_reg <= ST_IDLE;
                    end else if (beat) begin
                        if (last_beat) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            burst_cnt_reg <= burst_cnt_reg + 8'd1;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = beat && (grant_reg == IW'(gi));
        end
    endgenerate

    assign winc     = beat;
    assign wdata    = granted ? data_arr[grant_reg] : '0;
    assign grant_id = grant_reg;
    assign busy     = granted;

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for async_fifo_wr_arbiter.
// A transaction-level reference (owner / last / beats-in-burst) predicts the
// outputs every cycle; directed scenarios additionally pin literal cycle
// patterns. A second instance (NREQ=2, MAX_BURST=1) covers single-beat grants
// under a toggling full flag.
// ---------------------------------------------------------------------------
module tb_async_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int MB = 4;
    localparam int IW = 2;

    logic wclk   = 1'b0;
    logic wrst_n = 1'b0;
    always #5 wclk = ~wclk;

    // main instance
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data  = '0;
    logic [N-1:0]    req_ready;
    logic            wfull = 1'b0;
    logic            winc;
    logic [DW-1:0]   wdata;
    logic [IW-1:0]   grant_id;
    logic            busy;

    async_fifo_wr_arbiter #(.DSIZE(DW), .NREQ(N), .MAX_BURST(MB)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .wfull(wfull), .winc(winc), .wdata(wdata),
        .grant_id(grant_id), .busy(busy)
    );

    // two-requester, single-beat instance
    logic [1:0]  v2 = 2'b11;
    logic [15:0] d2 = 16'hB1A0;
    logic [1:0]  r2;
    logic        wfull2 = 1'b0;
    logic        winc2;
    logic [7:0]  wdata2;
    logic [0:0]  gid2;
    logic        busy2;

    async_fifo_wr_arbiter #(.DSIZE(8), .NREQ(2), .MAX_BURST(1)) dut2 (
        .wclk(wclk), .wrst_n(wrst_n), .req_valid(v2), .req_data(d2),
        .req_ready(r2), .wfull(wfull2), .winc(winc2), .wdata(wdata2),
        .grant_id(gid2), .busy(busy2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- producers ----------------
    int        p_left [N];
    logic [7:0] p_next [N];
    bit        p_on   [N];
    logic [N-1:0] hs_q = '0;
    bit        rand_mode = 0;
    int        wf_lo = -1, wf_hi = -2;
    int        cyc = 0;
    bit        check_en = 0;
    bit        chk2_en = 0;

    task automatic apply_inputs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]         = p_on[i] && (p_left[i] > 0);
            req_data[i*DW +: DW] = p_next[i];
        end
    endtask

    task automatic clear_producers();
        for (int i = 0; i < N; i++) begin
            p_left[i] = 0;
            p_next[i] = 8'h00;
            p_on[i]   = 1'b1;
        end
    endtask

    // Advance to the next cycle: retire accepted beats, then drive new inputs.
    task automatic step();
        @(posedge wclk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs_q[i] && p_left[i] > 0) begin
                p_left[i]--;
                p_next[i] = p_next[i] + 8'd1;
            end
        end
        if (rand_mode) begin
            for (int i = 0; i < N; i++) begin
                p_on[i] = ($urandom_range(0, 5) != 0);
                if (p_left[i] == 0 && $urandom_range(0, 7) == 0) begin
                    p_left[i] = $urandom_range(1, 12);
                end
            end
            wfull = ($urandom_range(0, 3) == 0);
        end else begin
            wfull = (cyc >= wf_lo) && (cyc <= wf_hi);
        end
        wfull2 = cyc[0];
        apply_inputs();
    endtask

    task automatic do_reset();
        wrst_n = 1'b0;
        clear_producers();
        apply_inputs();
        wfull  = 1'b0;
        wfull2 = 1'b0;
        repeat (3) @(posedge wclk);
        #1;
        wrst_n = 1'b1;
        cyc    = 0;
    endtask

    // ---------------- reference model ----------------
    // m_owner = -1 while arbitrating, else the requester holding the grant.
    int m_owner = -1;
    int m_last  = N - 1;
    int m_beats = 0;

    function automatic int model_pick();
        for (int k = 1; k <= N; k++) begin
            if (req_valid[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic model_beat();
        if (m_owner < 0) return 1'b0;
        return req_valid[m_owner] && !wfull;
    endfunction

    function automatic logic [N-1:0] model_ready();
        if (!model_beat()) return '0;
        return N'(1) << m_owner;
    endfunction

    function automatic logic [DW-1:0] model_wdata();
        if (m_owner < 0) return '0;
        return req_data[m_owner*DW +: DW];
    endfunction

    always @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            m_owner <= -1;
            m_last  <= N - 1;
            m_beats <= 0;
        end else if (m_owner < 0) begin
            if (model_pick() >= 0) begin
                m_owner <= model_pick();
                m_last  <= model_pick();
                m_beats <= 0;
            end
        end else if (!req_valid[m_owner]) begin
            m_owner <= -1;
        end else if (!wfull) begin
            if (m_beats + 1 == MB) m_owner <= -1;
            m_beats <= m_beats + 1;
        end
    end

    // ---------------- per-cycle compare + history ----------------
    logic       hist_winc [64];
    logic       hist_busy [64];
    logic [1:0] hist_gid  [64];
    logic [7:0] hist_data [64];
    int exp2 = 0;
    int wr2_cnt = 0;
    int wr_in_grant2 = 0;

    always @(negedge wclk) begin
        if (check_en) begin
            chk("winc",      winc,      model_beat());
            chk("req_ready", req_ready, model_ready());
            chk("wdata",     wdata,     model_wdata());
            chk("grant_id",  grant_id,  m_last);
            chk("busy",      busy,      m_owner >= 0);
            chk("no_winc_when_full", winc & wfull, 1'b0);
            chk("ready_onehot0", $onehot0(req_ready), 1'b1);
            chk("winc_eq_or_ready", winc, |req_ready);
        end
        if (chk2_en) begin
            chk("d2_no_winc_when_full", winc2 & wfull2, 1'b0);
            if (winc2) begin
                chk("d2_alt_grant", gid2, exp2);
                chk("d2_wdata", wdata2, exp2 == 0 ? 8'hA0 : 8'hB1);
                chk("d2_one_write_per_grant", wr_in_grant2, 0);
                exp2    <= 1 - exp2;
                wr2_cnt <= wr2_cnt + 1;
            end
            wr_in_grant2 <= busy2 ? wr_in_grant2 + (winc2 ? 1 : 0) : 0;
        end
        if (cyc >= 0 && cyc < 64) begin
            hist_winc[cyc] <= winc;
            hist_busy[cyc] <= busy;
            hist_gid[cyc]  <= grant_id;
            hist_data[cyc] <= wdata;
        end
        hs_q <= req_ready;
        cyc  <= cyc + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [9:0]  t1_pat;
        logic [7:0]  t1_data [10];
        int          t2_order [5];
        int          cnt;

        clear_producers();
        apply_inputs();
        @(posedge wclk);
        #1;
        check_en = 1'b1;

        // reset values
        do_reset();
        @(negedge wclk);
        #1;
        chk("reset_winc", winc, 1'b0);
        chk("reset_ready", req_ready, '0);
        chk("reset_wdata", wdata, '0);
        chk("reset_grant_id", grant_id, 2'd3);
        chk("reset_busy", busy, 1'b0);

        // 1: single requester, 6 items -> burst of 4, idle, re-grant for 2
        do_reset();
        p_left[0] = 6; p_next[0] = 8'h10;
        apply_inputs();
        repeat (10) step();
        @(negedge wclk);
        #1;
        t1_pat = 10'b0011011110;
        t1_data[1] = 8'h10; t1_data[2] = 8'h11; t1_data[3] = 8'h12;
        t1_data[4] = 8'h13; t1_data[6] = 8'h14; t1_data[7] = 8'h15;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("t1_winc_c%0d", c), hist_winc[c], t1_pat[c]);
            if (t1_pat[c]) chk($sformatf("t1_data_c%0d", c), hist_data[c], t1_data[c]);
            if (c >= 1) chk($sformatf("t1_gid_c%0d", c), hist_gid[c], 2'd0);
        end

        // 2: all valid -> 0,1,2,3,0 bursts of 4 with single idle gaps
        do_reset();
        for (int i = 0; i < N; i++) begin
            p_left[i] = 100; p_next[i] = 8'(8'h40 * i);
        end
        apply_inputs();
        repeat (25) step();
        @(negedge wclk);
        #1;
        t2_order[0] = 0; t2_order[1] = 1; t2_order[2] = 2; t2_order[3] = 3; t2_order[4] = 0;
        cnt = 0;
        for (int c = 0; c < 25; c++) cnt += hist_winc[c] ? 1 : 0;
        chk("t2_writes_in_25", cnt, 20);
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("t2_idle_%0d", j), hist_busy[5*j], 1'b0);
            for (int b = 1; b <= 4; b++) begin
                chk($sformatf("t2_grant_%0d_%0d", j, b), hist_gid[5*j+b], t2_order[j]);
                chk($sformatf("t2_winc_%0d_%0d", j, b), hist_winc[5*j+b], 1'b1);
            end
        end

        // 3: requester 2, FIFO full for 3 cycles after 2 beats
        do_reset();
        p_left[2] = 4; p_next[2] = 8'h30;
        wf_lo = 3; wf_hi = 5;
        apply_inputs();
        repeat (10) step();
        @(negedge wclk);
        #1;
        wf_lo = -1; wf_hi = -2;
        for (int c = 1; c <= 7; c++) begin
            chk($sformatf("t3_winc_c%0d", c), hist_winc[c], (c <= 2) || (c >= 6));
            chk($sformatf("t3_busy_c%0d", c), hist_busy[c], 1'b1);
            chk($sformatf("t3_gid_c%0d", c), hist_gid[c], 2'd2);
        end
        chk("t3_data_c6", hist_data[6], 8'h32);
        chk("t3_data_c7", hist_data[7], 8'h33);
        chk("t3_idle_c8", hist_busy[8], 1'b0);

        // 4: requester 1 drops valid after 2 beats, requester 3 waiting
        do_reset();
        p_left[1] = 2; p_next[1] = 8'h50;
        p_left[3] = 4; p_next[3] = 8'h70;
        apply_inputs();
        repeat (8) step();
        @(negedge wclk);
        #1;
        cnt = 0;
        for (int c = 0; c < 9; c++) cnt += (hist_winc[c] && hist_gid[c] == 2'd1) ? 1 : 0;
        chk("t4_req1_writes", cnt, 2);
        chk("t4_drop_cycle_no_winc", hist_winc[3], 1'b0);
        chk("t4_idle_c4", hist_busy[4], 1'b0);
        chk("t4_grant3_c5", hist_gid[5], 2'd3);
        chk("t4_winc_c5", hist_winc[5], 1'b1);
        chk("t4_data_c5", hist_data[5], 8'h70);

        // 5: reset during beat 3 of a grant to requester 1
        do_reset();
        p_left[1] = 100; p_next[1] = 8'h60;
        apply_inputs();
        repeat (3) step();
        @(negedge wclk);
        #1;
        chk("t5_beat3_winc", winc, 1'b1);
        chk("t5_beat3_gid", grant_id, 2'd1);
        wrst_n = 1'b0;
        #1;
        chk("t5_rst_winc", winc, 1'b0);
        chk("t5_rst_ready", req_ready, '0);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_gid", grant_id, 2'd3);
        repeat (2) @(posedge wclk);
        #1;
        wrst_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < N; i++) begin
            p_left[i] = 100; p_next[i] = 8'(8'h80 + 8'h10 * i);
        end
        apply_inputs();
        repeat (3) step();
        @(negedge wclk);
        #1;
        chk("t5_after_rst_gid", hist_gid[1], 2'd0);
        chk("t5_after_rst_winc", hist_winc[1], 1'b1);

        // 6: NREQ=2, MAX_BURST=1, FIFO full toggles every cycle
        do_reset();
        exp2 = 0; wr2_cnt = 0; wr_in_grant2 = 0;
        chk2_en = 1'b1;
        repeat (39) step();
        @(negedge wclk);
        #1;
        chk2_en = 1'b0;
        chk("t6_write_count", wr2_cnt, 19);

        // randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < N; i++) begin
            p_left[i] = $urandom_range(1, 12);
            p_next[i] = 8'($urandom_range(0, 255));
        end
        apply_inputs();
        rand_mode = 1'b1;
        repeat (1500) step();
        rand_mode = 1'b0;
        @(negedge wclk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
